// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a load/store initiator and a
// data-memory responder.
//   master : the initiator (core side); drives req_* and resp_ready.
//   slave  : the responder (memory side); drives req_ready and resp_*.
// Request: req_valid/req_ready handshake carrying write flag, byte address,
// store data and byte strobes. Response: resp_valid/resp_ready handshake
// carrying load data and an error flag.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory for the RV32I load/store
// port. Accepts one request in IDLE, commits stores / captures load data at
// the acceptance edge, waits LATENCY cycles, then presents the response
// until the initiator takes it.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (control state and outputs only)
//   bus : dmem_if.slave -- request and response handshakes
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, power of two, 4..65536
//   LATENCY     : wait states between acceptance and response, 0..15
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
  // Counter preload: the WAIT state lasts CNT_LOAD+1 cycles.
  localparam logic [3:0]  CNT_LOAD   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state;
  state_e          state_nxt;
  logic [3:0]      cnt;
  logic            accept;
  logic            req_err;
  logic [AW-1:0]   word_idx;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem [DEPTH_WORDS];

  assign accept   = (state == IDLE) && bus.req_valid;
  assign req_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= BYTE_LIMIT);
  assign word_idx = bus.req_addr[AW+1:2];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this combinational block
  // from inferring a latch on paths that do not change state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)  state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0)    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Outputs: handshake flags decode the state; payload comes from the
  // response register so it is stable throughout RESP.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

  // Wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response register, captured at acceptance. Only one request is ever
  // outstanding, so no later store can reach the word before it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (bus.req_write || req_err) ? 32'd0 : mem[word_idx];
    end
  end

  // Storage array with per-byte write enables. An erroring store may alias a
  // valid word index, so req_err must gate the write.
  // NOTE: the array has no reset; clearing it would turn the RAM into a
  // flop bank. Its contents survive rst, and no write is taken while rst is
  // high.
  always_ff @(posedge clk) begin
    if (accept && !rst && bus.req_write && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) mem[word_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Three instances with LATENCY 2, 0 and 5
// (DEPTH_WORDS 256) share the request payload; `sel` routes req_valid to one
// of them and selects which one is observed. A word-array model of each
// memory plus the address rules gives every expected response.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  logic        o_rr [3];
  logic        o_rv [3];
  logic        o_err[3];
  logic [31:0] o_rd [3];

  logic        obs_req_ready, obs_resp_valid, obs_resp_err;
  logic [31:0] obs_resp_rdata;

  int total = 0;
  int bad   = 0;

  // Behavioural memory image per instance (word addressed).
  logic [31:0] model [3][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_if bus ();
    assign bus.req_valid  = req_valid && (sel == g);
    assign bus.req_write  = req_write;
    assign bus.req_addr   = req_addr;
    assign bus.req_wdata  = req_wdata;
    assign bus.req_wstrb  = req_wstrb;
    assign bus.resp_ready = resp_ready;
    assign o_rr[g]  = bus.req_ready;
    assign o_rv[g]  = bus.resp_valid;
    assign o_err[g] = bus.resp_err;
    assign o_rd[g]  = bus.resp_rdata;

    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 0 : 5))
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  always_comb begin
    obs_req_ready  = o_rr[0];
    obs_resp_valid = o_rv[0];
    obs_resp_err   = o_err[0];
    obs_resp_rdata = o_rd[0];
    case (sel)
      1: begin
        obs_req_ready = o_rr[1]; obs_resp_valid = o_rv[1];
        obs_resp_err  = o_err[1]; obs_resp_rdata = o_rd[1];
      end
      2: begin
        obs_req_ready = o_rr[2]; obs_resp_valid = o_rv[2];
        obs_resp_err  = o_err[2]; obs_resp_rdata = o_rd[2];
      end
      default: ;
    endcase
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 0 : 5);
  endfunction

  // One complete request/response on instance `sel` with resp_ready high.
  // Expected values come from the address rules and the model image.
  // Entered and left at 1 time unit after a rising edge.
  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd, output logic e);
    int          cyc;
    logic        exp_e;
    logic [31:0] exp_rd;
    exp_e  = (a % 4 != 0) || (a >= 32'd1024);
    exp_rd = (w || exp_e) ? 32'd0 : model[sel][a / 4];
    if (w && !exp_e) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) model[sel][a / 4][8*b +: 8] = wd[8*b +: 8];
      end
    end
    resp_ready = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_wstrb  = ws;
    req_valid  = 1'b1;
    total++;
    if (obs_req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_before_req: req_ready=%b want 1 (dut %0d addr %h)", obs_req_ready, sel, a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (obs_resp_valid !== 1'b1 && cyc < 40) begin
      total++;
      if (obs_req_ready !== 1'b0) begin
        bad++; $display("FAIL ready_in_wait: req_ready=%b want 0 (dut %0d)", obs_req_ready, sel);
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc != lat_of(sel)) begin
      bad++; $display("FAIL latency: got %0d edges want %0d (dut %0d addr %h)", cyc, lat_of(sel), sel, a);
    end
    rd = obs_resp_rdata;
    e  = obs_resp_err;
    total++;
    if (rd !== exp_rd || e !== exp_e) begin
      bad++; $display("FAIL response: rdata=%h err=%b want rdata=%h err=%b (dut %0d w=%b addr %h)",
                      rd, e, exp_rd, exp_e, sel, w, a);
    end
    @(posedge clk); #1;
    total++;
    if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1) begin
      bad++; $display("FAIL handshake_done: resp_valid=%b req_ready=%b want 0/1 (dut %0d)",
                      obs_resp_valid, obs_req_ready, sel);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #1;
    total++;
    if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0 || obs_resp_rdata !== 32'd0 || obs_resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_initial: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                      obs_req_ready, obs_resp_valid, obs_resp_rdata, obs_resp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Park an erroring load in RESP, then reset mid-cycle.
    resp_ready = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h22;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (obs_resp_valid !== 1'b1 || obs_resp_err !== 1'b1) begin
      bad++; $display("FAIL reset_setup: valid=%b err=%b want 1/1", obs_resp_valid, obs_resp_err);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0 || obs_resp_rdata !== 32'd0 || obs_resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_async: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                      obs_req_ready, obs_resp_valid, obs_resp_rdata, obs_resp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_prefill();
    logic [31:0] rd;
    logic        e;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int w = 0; w < 64; w++) transact(1'b1, 32'(w * 4), $urandom, 4'hF, rd, e);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        e;
    sel = 0;
    transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
    transact(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      bad++; $display("FAIL store_load: rdata=%h err=%b want deadbeef/0", rd, e);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd;
    logic        e;
    sel = 0;
    transact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
    transact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
    transact(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'h11BB33DD) begin
      bad++; $display("FAIL byte_strobes: rdata=%h want 11bb33dd", rd);
    end
    transact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, e);
    total++;
    if (e !== 1'b0) begin
      bad++; $display("FAIL zero_strobe_err: err=%b want 0", e);
    end
    transact(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'h11BB33DD) begin
      bad++; $display("FAIL zero_strobe_data: rdata=%h want 11bb33dd", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        e;
    sel = 0;
    transact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e);
    transact(1'b0, 32'h22, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'd0 || e !== 1'b1) begin
      bad++; $display("FAIL misaligned_load: rdata=%h err=%b want 0/1", rd, e);
    end
    transact(1'b1, 32'h400, 32'h12345678, 4'hF, rd, e);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL range_store: err=%b want 1", e);
    end
    transact(1'b0, 32'h0, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
      bad++; $display("FAIL range_store_nowrite: rdata=%h err=%b want cafef00d/0", rd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        e;
    logic [31:0] held;
    sel = 1;
    held = model[1][7];
    resp_ready = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h1C;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (obs_resp_valid !== 1'b1 || obs_resp_rdata !== held) begin
      bad++; $display("FAIL bp_first: valid=%b rdata=%h want 1/%h", obs_resp_valid, obs_resp_rdata, held);
    end
    for (int i = 0; i < 5; i++) begin
      // A store to the same word mid-stall must be ignored.
      req_valid = (i == 2);
      req_write = (i == 2);
      req_wdata = 32'hFFFFFFFF;
      req_wstrb = 4'hF;
      @(posedge clk); #1;
      total++;
      if (obs_resp_valid !== 1'b1 || obs_resp_rdata !== held || obs_req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold: cycle %0d valid=%b rdata=%h ready=%b want 1/%h/0",
                        i, obs_resp_valid, obs_resp_rdata, obs_req_ready, held);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs_resp_valid !== 1'b0 || obs_req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", obs_resp_valid, obs_req_ready);
    end
    transact(1'b0, 32'h1C, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== held) begin
      bad++; $display("FAIL bp_ignored_store: rdata=%h want %h", rd, held);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        e;
    int          seen;
    sel = 2;
    // Store accepted just before reset must remain committed.
    model[2][5] = 32'hA5A5A5A5;
    req_write = 1'b1;
    req_addr  = 32'h14;
    req_wdata = 32'hA5A5A5A5;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs_req_ready !== 1'b1 || obs_resp_valid !== 1'b0) begin
      bad++; $display("FAIL wait_reset_state: ready=%b valid=%b want 1/0", obs_req_ready, obs_resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    transact(1'b0, 32'h14, 32'h0, 4'h0, rd, e);
    total++;
    if (rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL store_survives_reset: rdata=%h want a5a5a5a5", rd);
    end
    // Load discarded by reset: no response may follow.
    req_write = 1'b0;
    req_addr  = 32'h18;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (obs_resp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL discarded_resp: resp_valid seen %0d cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [3:0]  ws;
    logic        w, e;
    int          kind;
    for (int i = 0; i < 90; i++) begin
      sel  = $urandom_range(0, 2);
      w    = 1'($urandom_range(0, 1));
      wd   = $urandom;
      ws   = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, 63)) * 4;
      if (kind == 0)      a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
      transact(w, a, wd, ws, rd, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    sel        = 0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wstrb  = 4'd0;
    resp_ready = 1'b1;
    test_reset();
    test_prefill();
    test_store_load();
    test_strobes();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
